rrv_hazard_unit: RTL and testbench



---
 rtl/rrv_hazard_pkg.sv | 21 ++
 rtl/rrv_src_decode.sv | 33 +++
 rtl/rrv_hazard_unit.sv | 111 +++++++++++
 tb/tb_rrv_hazard_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rrv_hazard_pkg.sv
// Shared constants and types for the rrv hazard/stall control logic.
package rrv_hazard_pkg;

  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_I_ARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;

  // Load-use bubble count is 1..MEM_LAT_MAX; the bubble counter is sized to hold it.
  localparam int MEM_LAT_MAX = 15;
  localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hazard_state_e;

endpackage

// File: rtl/rrv_src_decode.sv
// Opcode-based source-register usage decode; shared with the forwarding unit.
module rrv_src_decode
  import rrv_hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [31:0]               instruction,
  output logic                      rs1_used,
  output logic                      rs2_used,
  output logic [REG_ADDR_WIDTH-1:0] rs1,
  output logic [REG_ADDR_WIDTH-1:0] rs2
);

  logic unused_instr;
  assign unused_instr = ^instruction;

  assign rs1 = instruction[15 +: REG_ADDR_WIDTH];
  assign rs2 = instruction[20 +: REG_ADDR_WIDTH];

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (instruction[6:0])
      OP_R, OP_STORE, OP_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_I_ARITH, OP_LOAD, OP_JALR: rs1_used = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/rrv_hazard_unit.sv
// Pipeline stall/flush control: load-use bubbles, data-memory freeze, branch flush
// and a saturating stall-cycle counter.
module rrv_hazard_unit
  import rrv_hazard_pkg::*;
#(
  parameter int MEM_LAT        = 1,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               id_instruction,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      ex_load,
  input  logic                      mem_access,
  input  logic                      dmem_ready,
  input  logic                      ex_branch_taken,
  output logic                      pc_en,
  output logic                      if_id_en,
  output logic                      id_ex_en,
  output logic                      ex_mem_en,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic [CNT_W-1:0]          stall_cycles,
  output hazard_state_e             dbg_state
);

  hazard_state_e          state_q;
  logic [LAT_CNT_W-1:0]   cnt_q;
  logic                   rs1_used, rs2_used;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2;
  logic                   hazard, freeze, bubble;

  rrv_src_decode #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_src_decode (
    .instruction (id_instruction),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .rs1         (rs1),
    .rs2         (rs2)
  );

  assign hazard = ex_load && (ex_rd_addr != '0) &&
                  ((rs1_used && (rs1 == ex_rd_addr)) || (rs2_used && (rs2 == ex_rd_addr)));
  assign freeze = mem_access && !dmem_ready;
  // LU_STALL keeps bubbling without re-checking ID: the load has already left EX.
  assign bubble = (state_q == ST_LU_STALL) || hazard;
  assign dbg_state = state_q;

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst) begin
      // keep the pipeline free-running while in reset
    end else if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (bubble) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      stall_cycles <= '0;
    end else begin
      if (!pc_en && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;

      if (freeze) begin
        if (state_q == ST_IDLE)
          state_q <= ST_MEM_WAIT;
      end else if (ex_branch_taken) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_LU_STALL: begin
            if (cnt_q == LAT_CNT_W'(1)) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - LAT_CNT_W'(1);
            end
          end
          default: begin
            // MEM_WAIT only ever saves IDLE, so on release it behaves as IDLE
            state_q <= ST_IDLE;
            if (hazard && (MEM_LAT > 1)) begin
              state_q <= ST_LU_STALL;
              cnt_q   <= LAT_CNT_W'(MEM_LAT - 1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rrv_hazard_unit.sv
// Bench for rrv_hazard_unit: three instances (lat 1, lat 3, lat 3 with 3-bit counter)
// share stimulus and are checked against a cycle-level behavioural model.
module tb_rrv_hazard_unit;
  import rrv_hazard_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] id_instruction = '0;
  logic [4:0]  ex_rd_addr = '0;
  logic        ex_load = 1'b0;
  logic        mem_access = 1'b0;
  logic        dmem_ready = 1'b1;
  logic        ex_branch_taken = 1'b0;

  wire [2:0]   pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush;
  logic [15:0] sc1, sc3;
  logic [2:0]  scs;
  hazard_state_e st0, st1, st2;

  int n_checks = 0;
  int n_fail   = 0;
  int lat[3]  = '{1, 3, 3};
  int cmax[3] = '{65535, 65535, 7};
  int m_bub[3], m_cnt[3], nx_bub[3], nx_cnt[3];
  logic [21:0] exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;

  rrv_hazard_unit #(.MEM_LAT(1), .REG_ADDR_WIDTH(5), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .id_instruction(id_instruction), .ex_rd_addr(ex_rd_addr),
    .ex_load(ex_load), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .ex_branch_taken(ex_branch_taken), .pc_en(pc_en[0]), .if_id_en(if_id_en[0]),
    .id_ex_en(id_ex_en[0]), .ex_mem_en(ex_mem_en[0]), .if_id_flush(if_id_flush[0]),
    .id_ex_flush(id_ex_flush[0]), .stall_cycles(sc1), .dbg_state(st0));

  rrv_hazard_unit #(.MEM_LAT(3), .REG_ADDR_WIDTH(5), .CNT_W(16)) d3 (
    .clk(clk), .rst(rst), .id_instruction(id_instruction), .ex_rd_addr(ex_rd_addr),
    .ex_load(ex_load), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .ex_branch_taken(ex_branch_taken), .pc_en(pc_en[1]), .if_id_en(if_id_en[1]),
    .id_ex_en(id_ex_en[1]), .ex_mem_en(ex_mem_en[1]), .if_id_flush(if_id_flush[1]),
    .id_ex_flush(id_ex_flush[1]), .stall_cycles(sc3), .dbg_state(st1));

  rrv_hazard_unit #(.MEM_LAT(3), .REG_ADDR_WIDTH(5), .CNT_W(3)) ds (
    .clk(clk), .rst(rst), .id_instruction(id_instruction), .ex_rd_addr(ex_rd_addr),
    .ex_load(ex_load), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .ex_branch_taken(ex_branch_taken), .pc_en(pc_en[2]), .if_id_en(if_id_en[2]),
    .id_ex_en(id_ex_en[2]), .ex_mem_en(ex_mem_en[2]), .if_id_flush(if_id_flush[2]),
    .id_ex_flush(id_ex_flush[2]), .stall_cycles(scs), .dbg_state(st2));

  function automatic logic [31:0] mk(logic [6:0] op, int rd, int rs1, int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), op};
  endfunction

  function automatic logic [15:0] cnt_of(int i);
    return (i == 0) ? sc1 : (i == 1) ? sc3 : {13'b0, scs};
  endfunction

  function automatic hazard_state_e st_of(int i);
    return (i == 0) ? st0 : (i == 1) ? st1 : st2;
  endfunction

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, stall_cycles}
  function automatic logic [21:0] obs(int i);
    return {pc_en[i], if_id_en[i], id_ex_en[i], ex_mem_en[i],
            if_id_flush[i], id_ex_flush[i], cnt_of(i)};
  endfunction

  function automatic bit model_hazard(logic [31:0] ins, logic [4:0] rd, logic ld);
    logic [6:0] op;
    bit u1, u2;
    op = ins[6:0];
    u1 = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    return ld && (rd != 0) && ((u1 && ins[19:15] == rd) || (u2 && ins[24:20] == rd));
  endfunction

  // Reference model: pending bubbles and stall count per instance, from the pipeline rules.
  task automatic eval_model();
    bit hz;
    hz = model_hazard(id_instruction, ex_rd_addr, ex_load);
    for (int i = 0; i < 3; i++) begin
      logic [5:0] c;
      int s;
      s = 0;
      nx_bub[i] = m_bub[i];
      if (rst) begin
        c = 6'b111100; nx_bub[i] = 0;
      end else if (mem_access && !dmem_ready) begin
        c = 6'b000000; s = 1;
      end else if (ex_branch_taken) begin
        c = 6'b111111; nx_bub[i] = 0;
      end else if (m_bub[i] > 0) begin
        c = 6'b001101; s = 1; nx_bub[i] = m_bub[i] - 1;
      end else if (hz) begin
        c = 6'b001101; s = 1; nx_bub[i] = lat[i] - 1;
      end else begin
        c = 6'b111100;
      end
      nx_cnt[i] = rst ? 0 : ((m_cnt[i] + s > cmax[i]) ? cmax[i] : m_cnt[i] + s);
      exp_q.push_back({c, 16'(m_cnt[i])});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      m_bub[i] = nx_bub[i];
      m_cnt[i] = nx_cnt[i];
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_instruction = '0; ex_rd_addr = '0; ex_load = 1'b0;
    mem_access = 1'b0; dmem_ready = 1'b1; ex_branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    eval_model();
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_load = 1'b1; ex_rd_addr = 5'd6; id_instruction = mk(7'b0110011, 28, 6, 30);
    @(negedge clk);
    eval_model();
    exp_q.delete();
    tick();
    for (int step = 0; step < 2; step++) begin
      if (step == 1) begin rst = 1'b0; idle_inputs(); end
      @(negedge clk);
      eval_model();
      for (int i = 0; i < 3; i++) begin
        logic [21:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (obs(i) !== e) begin
          n_fail++;
          $display("FAIL reset[%0d] inst%0d: got %h required %h", step, i, obs(i), e);
        end
      end
      if (step == 1)
        for (int i = 0; i < 3; i++) begin
          n_checks++;
          if (st_of(i) !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state inst%0d: got %0d required %0d", i, st_of(i), ST_IDLE);
          end
        end
      tick();
    end
  endtask

  task automatic test_load_use(string name, logic [31:0] ins, int rd, bit stalls);
    int pcz[3];
    do_reset();
    pcz = '{0, 0, 0};
    for (int step = 0; step < 5; step++) begin
      ex_load = (step == 0);
      ex_rd_addr = (step == 0) ? 5'(rd) : 5'd0;
      id_instruction = ins;
      @(negedge clk);
      eval_model();
      for (int i = 0; i < 3; i++) begin
        logic [21:0] e;
        if (!pc_en[i]) pcz[i]++;
        e = exp_q.pop_front();
        n_checks++;
        if (obs(i) !== e) begin
          n_fail++;
          $display("FAIL %s[%0d] inst%0d: got %h required %h", name, step, i, obs(i), e);
        end
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      int want;
      want = stalls ? lat[i] : 0;
      n_checks++;
      if (pcz[i] != want || cnt_of(i) != 16'(want)) begin
        n_fail++;
        $display("FAIL %s_bubbles inst%0d: got %0d/%0d required %0d", name, i, pcz[i], cnt_of(i), want);
      end
    end
  endtask

  task automatic test_freeze_in_stall();
    do_reset();
    for (int step = 0; step < 9; step++) begin
      ex_load = (step == 0);
      ex_rd_addr = (step == 0) ? 5'd6 : 5'd0;
      id_instruction = mk(7'b0110011, 28, 6, 30);
      mem_access = (step >= 1 && step <= 5);
      dmem_ready = !(step >= 1 && step <= 4);
      @(negedge clk);
      eval_model();
      for (int i = 0; i < 3; i++) begin
        logic [21:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (obs(i) !== e) begin
          n_fail++;
          $display("FAIL freeze[%0d] inst%0d: got %h required %h", step, i, obs(i), e);
        end
      end
      tick();
    end
    n_checks++;
    if (sc3 !== 16'd7 || sc1 !== 16'd5 || scs !== 3'd7) begin
      n_fail++;
      $display("FAIL freeze_total: got %0d/%0d/%0d required 5/7/7", sc1, sc3, scs);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int step = 0; step < 5; step++) begin
      ex_load = (step == 0 || step == 2);
      ex_rd_addr = ex_load ? 5'd6 : 5'd0;
      id_instruction = (step == 1) ? 32'h0 : mk(7'b0110011, 28, 6, 30);
      ex_branch_taken = (step == 0 || step == 3);
      @(negedge clk);
      eval_model();
      for (int i = 0; i < 3; i++) begin
        logic [21:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (obs(i) !== e) begin
          n_fail++;
          $display("FAIL flush[%0d] inst%0d: got %h required %h", step, i, obs(i), e);
        end
      end
      tick();
      if (step == 0 || step == 3)
        for (int i = 0; i < 3; i++) begin
          n_checks++;
          if (st_of(i) !== ST_IDLE) begin
            n_fail++;
            $display("FAIL flush_state[%0d] inst%0d: got %0d required %0d", step, i, st_of(i), ST_IDLE);
          end
        end
    end
    n_checks++;
    if (sc1 !== 16'd1 || sc3 !== 16'd1) begin
      n_fail++;
      $display("FAIL flush_total: got %0d/%0d required 1/1", sc1, sc3);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int step = 0; step < 3; step++) begin
      ex_load = (step == 0);
      ex_rd_addr = (step == 0) ? 5'd6 : 5'd0;
      id_instruction = mk(7'b0110011, 28, 6, 30);
      rst = (step == 1);
      @(negedge clk);
      eval_model();
      for (int i = 0; i < 3; i++) begin
        logic [21:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (obs(i) !== e) begin
          n_fail++;
          $display("FAIL reset_mid[%0d] inst%0d: got %h required %h", step, i, obs(i), e);
        end
      end
      if (step == 2) begin
        n_checks++;
        if (st1 !== ST_IDLE || sc3 !== 16'd0) begin
          n_fail++;
          $display("FAIL reset_mid_state: got %0d/%0d required %0d/0", st1, sc3, ST_IDLE);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[8];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1100111, 7'b0110111, 7'b1101111};
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = ($urandom_range(0, 99) == 0);
      ex_load = $urandom_range(0, 1);
      ex_rd_addr = 5'($urandom_range(0, 3));
      id_instruction = mk(ops[$urandom_range(0, 7)], $urandom_range(0, 31),
                          $urandom_range(0, 3), $urandom_range(0, 3));
      mem_access = ($urandom_range(0, 3) == 0);
      dmem_ready = $urandom_range(0, 1);
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      eval_model();
      for (int i = 0; i < 3; i++) begin
        logic [21:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (obs(i) !== e) begin
          n_fail++;
          $display("FAIL random[%0d] inst%0d: got %h required %h", cyc, i, obs(i), e);
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_bub[i] = 0; m_cnt[i] = 0; nx_bub[i] = 0; nx_cnt[i] = 0;
    end
    test_reset();
    test_load_use("lw_add",  mk(7'b0110011, 28, 6, 30), 6, 1'b1);
    test_load_use("lw_sw",   mk(7'b0100011, 0, 9, 6),   6, 1'b1);
    test_load_use("lw_lui",  mk(7'b0110111, 6, 6, 6),   6, 1'b0);
    test_load_use("x0_add",  mk(7'b0110011, 1, 0, 0),   0, 1'b0);
    test_load_use("lw_beq",  mk(7'b1100011, 0, 6, 5),   5, 1'b1);
    test_load_use("lw_jalr", mk(7'b1100111, 1, 7, 0),   7, 1'b1);
    test_freeze_in_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
